mac_seq_ctrl: RTL and testbench



---
 rtl/mac_seq_ctrl.sv | 161 ++++++++++++++++
 tb/tb_mac_seq_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_seq_ctrl.sv
// Job sequencer for the external int8/fp16 MAC: loads a bias, streams operand pairs, presents the result.
// Optional: define MAC_SEQ_STALL_CNT_EN to add the stat_stall input-starvation counter.
module mac_seq_ctrl #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             cfg_mode,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [27:0]      cfg_bias_int,
  input  logic [17:0]      cfg_bias_fp,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_value,
  input  logic [15:0]      in_weight,
  output logic             mac_mode,
  output logic [15:0]      mac_value,
  output logic [15:0]      mac_weight,
  output logic [27:0]      mac_ints,
  output logic [17:0]      mac_fps,
  input  logic [27:0]      mac_intr,
  input  logic [17:0]      mac_fpr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_mode,
  output logic [27:0]      out_int,
`ifdef MAC_SEQ_STALL_CNT_EN
  output logic [15:0]      stat_stall,
`endif
  output logic [17:0]      out_fp
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [27:0]      acc_int_q, acc_int_d;
  logic [17:0]      acc_fp_q, acc_fp_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             mode_q, mode_d;
  logic [27:0]      out_int_q, out_int_d;
  logic [17:0]      out_fp_q, out_fp_d;
  logic             out_mode_q, out_mode_d;
  logic [LEN_W-1:0] cnt_inc;

  assign cnt_inc = cnt_q + LEN_W'(1);

  // NOTE: every signal written here gets its default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    acc_int_d = acc_int_q;
    acc_fp_d  = acc_fp_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    mode_d    = mode_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d    = cfg_mode;
          len_d     = cfg_len;
          acc_int_d = cfg_bias_int;
          acc_fp_d  = cfg_bias_fp;
          cnt_d     = '0;
          state_d   = (cfg_len == '0) ? S_DONE : S_ACC;
        end
      end
      S_ACC: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (in_valid) begin
          if (mode_q) acc_fp_d  = mac_fpr;
          else        acc_int_d = mac_intr;
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (abort || out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Result registers only load on the way into DONE, so a new start cannot disturb the last result.
  always_comb begin
    out_int_d  = out_int_q;
    out_fp_d   = out_fp_q;
    out_mode_d = out_mode_q;
    if (state_d == S_DONE) begin
      out_int_d  = acc_int_d;
      out_fp_d   = acc_fp_d;
      out_mode_d = mode_d;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      acc_int_q  <= '0;
      acc_fp_q   <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      mode_q     <= 1'b0;
      out_int_q  <= '0;
      out_fp_q   <= '0;
      out_mode_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_int_q  <= acc_int_d;
      acc_fp_q   <= acc_fp_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      mode_q     <= mode_d;
      out_int_q  <= out_int_d;
      out_fp_q   <= out_fp_d;
      out_mode_q <= out_mode_d;
    end
  end

  assign busy      = (state_q == S_ACC) || (state_q == S_DONE);
  assign in_ready  = (state_q == S_ACC);
  assign out_valid = (state_q == S_DONE);
  assign out_int   = out_int_q;
  assign out_fp    = out_fp_q;
  assign out_mode  = out_mode_q;

  assign mac_mode   = mode_q;
  assign mac_value  = in_value;
  assign mac_weight = in_weight;
  assign mac_ints   = acc_int_q;
  assign mac_fps    = acc_fp_q;

`ifdef MAC_SEQ_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == S_IDLE && start) begin
      stall_d = '0;
    end else if (state_q == S_ACC && !in_valid && stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stat_stall = stall_q;
`endif

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl: job table, hand-written corner sequences, randomized jobs vs. a job-level model.
module tb_mac_seq_ctrl;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start, abort, cfg_mode;
  logic [LEN_W-1:0] cfg_len;
  logic [27:0]      cfg_bias_int;
  logic [17:0]      cfg_bias_fp;
  logic             busy, in_valid, in_ready;
  logic [15:0]      in_value, in_weight;
  logic             mac_mode;
  logic [15:0]      mac_value, mac_weight;
  logic [27:0]      mac_ints, mac_intr;
  logic [17:0]      mac_fps, mac_fpr;
  logic             out_valid, out_ready, out_mode;
  logic [27:0]      out_int;
  logic [17:0]      out_fp;
`ifdef MAC_SEQ_STALL_CNT_EN
  logic [15:0]      stat_stall;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Stand-in for the external MAC: int8 signed multiply-add on the low bytes; a simple fp-field mix.
  function automatic logic [27:0] int_mac(input logic [27:0] b, input logic [15:0] v, input logic [15:0] w);
    int a, c;
    a = int'($signed(v[7:0]));
    c = int'($signed(w[7:0]));
    return b + 28'(a * c);
  endfunction

  function automatic logic [17:0] fp_mac(input logic [17:0] b, input logic [15:0] v, input logic [15:0] w);
    return b + {2'b00, v ^ {w[7:0], w[15:8]}};
  endfunction

  assign mac_intr = int_mac(mac_ints, mac_value, mac_weight);
  assign mac_fpr  = fp_mac(mac_fps, mac_value, mac_weight);

  mac_seq_ctrl #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_mode(cfg_mode), .cfg_len(cfg_len), .cfg_bias_int(cfg_bias_int), .cfg_bias_fp(cfg_bias_fp),
    .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value), .in_weight(in_weight),
    .mac_mode(mac_mode), .mac_value(mac_value), .mac_weight(mac_weight),
    .mac_ints(mac_ints), .mac_fps(mac_fps), .mac_intr(mac_intr), .mac_fpr(mac_fpr),
    .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode), .out_int(out_int),
`ifdef MAC_SEQ_STALL_CNT_EN
    .stat_stall(stat_stall),
`endif
    .out_fp(out_fp)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic            mode;
    logic [7:0]      len;
    logic [27:0]     bias_int;
    logic [17:0]     bias_fp;
    logic [2:0][15:0] v;
    logic [2:0][15:0] w;
    logic [27:0]     exp_int;
    logic [17:0]     exp_fp;
  } vec_t;

  vec_t vecs[5];

  // Called just after a negedge; returns just after the negedge following the accepting posedge.
  task automatic issue_start(input logic m, input logic [7:0] l, input logic [27:0] bi, input logic [17:0] bf);
    start = 1'b1; cfg_mode = m; cfg_len = l; cfg_bias_int = bi; cfg_bias_fp = bf;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t t);
    string tag;
    tag = $sformatf("vec%0d", idx);
    issue_start(t.mode, t.len, t.bias_int, t.bias_fp);
    for (int k = 0; k < int'(t.len); k++) begin
      check({tag, " in_ready"}, 32'(in_ready), 1);
      in_valid = 1'b1; in_value = t.v[k]; in_weight = t.w[k];
      @(negedge clk);
    end
    in_valid = 1'b0;
    check({tag, " out_valid"}, 32'(out_valid), 1);
    check({tag, " in_ready_done"}, 32'(in_ready), 0);
    check({tag, " out_int"}, 32'(out_int), 32'(t.exp_int));
    check({tag, " out_fp"}, 32'(out_fp), 32'(t.exp_fp));
    check({tag, " out_mode"}, 32'(out_mode), 32'(t.mode));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " out_valid_drop"}, 32'(out_valid), 0);
    check({tag, " busy_drop"}, 32'(busy), 0);
    check({tag, " out_int_hold"}, 32'(out_int), 32'(t.exp_int));
  endtask

  task automatic random_jobs(input int n_jobs);
    logic        m;
    int          l, k, stalls, waits;
    logic [27:0] acc_i;
    logic [17:0] acc_f;
    logic [15:0] v, w;
    for (int j = 0; j < n_jobs; j++) begin
      m = 1'($urandom_range(0, 1));
      l = $urandom_range(1, 6);
      acc_i = 28'($urandom);
      acc_f = 18'($urandom);
      issue_start(m, 8'(l), acc_i, acc_f);
      k = 0; stalls = 0;
      while (k < l) begin
        check("rnd in_ready", 32'(in_ready), 1);
        start = 1'($urandom_range(0, 1));
        cfg_mode = ~m; cfg_len = 8'($urandom); cfg_bias_int = 28'($urandom); cfg_bias_fp = 18'($urandom);
        if ($urandom_range(0, 3) != 0) begin
          v = 16'($urandom); w = 16'($urandom);
          in_valid = 1'b1; in_value = v; in_weight = w;
          check("rnd mac_mode", 32'(mac_mode), 32'(m));
          check("rnd mac_ints", 32'(mac_ints), 32'(acc_i));
          check("rnd mac_fps", 32'(mac_fps), 32'(acc_f));
          if (m) acc_f = fp_mac(acc_f, v, w);
          else   acc_i = int_mac(acc_i, v, w);
          k++;
        end else begin
          in_valid = 1'b0;
          in_value = 16'($urandom);
          stalls++;
        end
        @(negedge clk);
      end
      in_valid = 1'b0;
      waits = $urandom_range(0, 3);
      for (int c = 0; c <= waits; c++) begin
        check("rnd out_valid", 32'(out_valid), 1);
        check("rnd out_int", 32'(out_int), 32'(acc_i));
        check("rnd out_fp", 32'(out_fp), 32'(acc_f));
        check("rnd out_mode", 32'(out_mode), 32'(m));
`ifdef MAC_SEQ_STALL_CNT_EN
        check("rnd stat_stall", 32'(stat_stall), 32'(stalls));
`endif
        if (c < waits) begin
          start = 1'($urandom_range(0, 1));
          @(negedge clk);
        end
      end
      start = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("rnd idle", 32'(busy), 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v0, w0, v1, w1;
    logic [27:0] held_int;
    logic [17:0] held_fp;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; cfg_mode = 1'b0; cfg_len = '0;
    cfg_bias_int = '0; cfg_bias_fp = '0; in_valid = 1'b0; in_value = '0; in_weight = '0;
    out_ready = 1'b0;

    vecs[0] = '{1'b0, 8'd3, 28'd10, 18'h2AAAA, {16'd5, 16'd4, 16'd2},
                {16'h0005, 16'h00FF, 16'h0003}, 28'd37, 18'h2AAAA};
    vecs[1] = '{1'b0, 8'd0, 28'h8000001, 18'h00001, 48'h0, 48'h0, 28'h8000001, 18'h00001};
    vecs[2] = '{1'b0, 8'd1, 28'd0, 18'h15555, {16'd0, 16'd0, 16'd3},
                {16'd0, 16'd0, 16'h0002}, 28'd6, 18'h15555};
    vecs[3] = '{1'b0, 8'd2, 28'hFFFFFFF, 18'h00000, {16'd0, 16'h007F, 16'h0080},
                {16'd0, 16'h0001, 16'h0080}, 28'h000407E, 18'h00000};
    vecs[4] = '{1'b1, 8'd0, 28'h1234567, 18'h3FFFF, 48'h0, 48'h0, 28'h1234567, 18'h3FFFF};

    @(negedge clk);
    check("rst busy", 32'(busy), 0);
    check("rst in_ready", 32'(in_ready), 0);
    check("rst out_valid", 32'(out_valid), 0);
    check("rst out_mode", 32'(out_mode), 0);
    check("rst out_int", 32'(out_int), 0);
    check("rst out_fp", 32'(out_fp), 0);
    check("rst mac_ints", 32'(mac_ints), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Operand traffic and abort while idle must not start anything.
    in_valid = 1'b1; abort = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; abort = 1'b0;
    check("idle ignores in_valid", 32'(in_ready), 0);
    check("idle ignores abort", 32'(busy), 0);

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    // fp job with a three-cycle gap between pairs.
    v0 = 16'($urandom); w0 = 16'($urandom); v1 = 16'($urandom); w1 = 16'($urandom);
    issue_start(1'b1, 8'd2, 28'h0ABCDEF, 18'h0);
    in_valid = 1'b1; in_value = v0; in_weight = w0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) begin
      check("fp gap in_ready", 32'(in_ready), 1);
      @(negedge clk);
    end
    in_valid = 1'b1; in_value = v1; in_weight = w1;
    @(negedge clk);
    in_valid = 1'b0;
    check("fp out_valid", 32'(out_valid), 1);
    check("fp out_fp", 32'(out_fp), 32'(fp_mac(fp_mac(18'h0, v0, w0), v1, w1)));
    check("fp out_int", 32'(out_int), 32'h0ABCDEF);
    check("fp out_mode", 32'(out_mode), 1);
`ifdef MAC_SEQ_STALL_CNT_EN
    check("fp stat_stall", 32'(stat_stall), 3);
`endif
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Backpressure in DONE with a stray start; start coincident with out_ready is not seen.
    issue_start(1'b0, 8'd1, 28'd100, 18'h0123);
    in_valid = 1'b1; in_value = 16'd7; in_weight = 16'd9;
    @(negedge clk);
    in_valid = 1'b0;
    held_int = out_int; held_fp = out_fp;
    check("bp first result", 32'(held_int), 163);
    for (int c = 0; c < 5; c++) begin
      start = (c == 2); cfg_len = 8'd0; cfg_bias_int = 28'h5555555; cfg_bias_fp = 18'h2222;
      check("bp out_valid", 32'(out_valid), 1);
      check("bp out_int stable", 32'(out_int), 32'(held_int));
      check("bp out_fp stable", 32'(out_fp), 32'(held_fp));
      @(negedge clk);
    end
    start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; out_ready = 1'b0;
    check("bp idle after ready", 32'(busy), 0);
    check("bp coincident start dropped", 32'(out_valid), 0);
    @(negedge clk);
    check("bp still idle", 32'(busy), 0);

    // Abort after two handshakes, with a pair offered in the abort cycle.
    issue_start(1'b0, 8'd4, 28'd0, 18'h0);
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_value = 16'd1; in_weight = 16'd1;
      @(negedge clk);
    end
    in_valid = 1'b1; abort = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; abort = 1'b0;
    check("abort busy", 32'(busy), 0);
    check("abort acc held", 32'(mac_ints), 2);
    for (int c = 0; c < 3; c++) begin
      check("abort no out_valid", 32'(out_valid), 0);
      @(negedge clk);
    end
    run_vec(9, '{1'b0, 8'd1, 28'd0, 18'h0, {16'd0, 16'd0, 16'd3}, {16'd0, 16'd0, 16'h0002}, 28'd6, 18'h0});

    // Abort beats out_ready in DONE.
    issue_start(1'b0, 8'd0, 28'd55, 18'h0);
    check("abort done valid", 32'(out_valid), 1);
    abort = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0; out_ready = 1'b0;
    check("abort done idle", 32'(busy), 0);

    random_jobs(40);

    // Asynchronous reset mid-ACC, between clock edges.
    issue_start(1'b1, 8'd4, 28'd9, 18'h9);
    in_valid = 1'b1; in_value = 16'h1234; in_weight = 16'h5678;
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst in_ready", 32'(in_ready), 0);
    check("arst busy", 32'(busy), 0);
    check("arst out_int", 32'(out_int), 0);
    check("arst out_fp", 32'(out_fp), 0);
    check("arst mac_fps", 32'(mac_fps), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post arst busy", 32'(busy), 0);
    check("post arst out_valid", 32'(out_valid), 0);
    check("post arst out_mode", 32'(out_mode), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
